// File: rtl/i2c_write_master.sv
`default_nettype none
// ============================================================================
// Module   : i2c_write_master
// Purpose  : Bit-level I2C write engine. Sends one 24-bit frame per request
//            as START, three bytes each followed by an ACK slot, then STOP.
//            Bus timing comes from an internal quarter-bit tick generator
//            running on the system clock.
// Ports    : clk       system clock
//            rst_n     asynchronous active-low reset
//            go        transfer request, rising edge accepted while idle
//            i2c_data  frame {addr+R/W, byte1, byte0}, sent MSB first
//            busy      high from accept until completion
//            done      sticky completion flag, cleared by the next accept
//            ack_err   at least one NACK seen in the last transfer
//            i2c_sclk  SCL, push-pull
//            i2c_sdat  SDA, open-drain (driven 0 or released)
// Options  : I2C_NACK_ABORT_EN - when defined, a NACK in any ACK slot ends
//            the transfer with STOP straight after that slot.
// Revision : 1.0 - initial release
// ============================================================================
module i2c_write_master #(
   parameter int CLK_FREQ = 200000000,
   parameter int I2C_FREQ = 20000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        go,
   input  logic [23:0] i2c_data,
   output logic        busy,
   output logic        done,
   output logic        ack_err,
   output logic        i2c_sclk,
   inout  wire         i2c_sdat
);

   localparam int QDIV = CLK_FREQ / (4 * I2C_FREQ);
   localparam int DIVW = (QDIV > 1) ? $clog2(QDIV) : 1;
   localparam logic [DIVW-1:0] DIV_LAST = DIVW'(QDIV - 1);

   generate
      if (QDIV < 2) begin : g_qdiv_check
         $error("i2c_write_master: CLK_FREQ/(4*I2C_FREQ) must be at least 2");
      end
   endgenerate

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      BIT   = 3'd2,
      ACK   = 3'd3,
      STOP  = 3'd4
   } state_t;

   state_t            state, state_n;
   logic [1:0]        quarter, quarter_n;
   logic [2:0]        bit_idx, bit_idx_n;
   logic [1:0]        byte_idx, byte_idx_n;
   logic [23:0]       shreg, shreg_n;
   logic [DIVW-1:0]   div, div_n;
   logic              go_q;
   logic              busy_n, done_n, ack_err_n, scl_n;
   logic              sda_oe, sda_oe_n;   // 1 = pull SDA low
   logic              tick;
`ifdef I2C_NACK_ABORT_EN
   logic              nack, nack_n;
`endif

   // Open-drain SDA: only ever pulled low or released.
   assign i2c_sdat = sda_oe ? 1'b0 : 1'bz;

   assign tick = (state != IDLE) && (div == DIV_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         quarter  <= 2'd0;
         bit_idx  <= 3'd0;
         byte_idx <= 2'd0;
         shreg    <= 24'd0;
         div      <= '0;
         go_q     <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         ack_err  <= 1'b0;
         i2c_sclk <= 1'b1;
         sda_oe   <= 1'b0;
`ifdef I2C_NACK_ABORT_EN
         nack     <= 1'b0;
`endif
      end else begin
         state    <= state_n;
         quarter  <= quarter_n;
         bit_idx  <= bit_idx_n;
         byte_idx <= byte_idx_n;
         shreg    <= shreg_n;
         div      <= div_n;
         go_q     <= go;
         busy     <= busy_n;
         done     <= done_n;
         ack_err  <= ack_err_n;
         i2c_sclk <= scl_n;
         sda_oe   <= sda_oe_n;
`ifdef I2C_NACK_ABORT_EN
         nack     <= nack_n;
`endif
      end
   end

   always_comb begin
      state_n    = state;
      quarter_n  = quarter;
      bit_idx_n  = bit_idx;
      byte_idx_n = byte_idx;
      shreg_n    = shreg;
      busy_n     = busy;
      done_n     = done;
      ack_err_n  = ack_err;
      scl_n      = i2c_sclk;
      sda_oe_n   = sda_oe;
`ifdef I2C_NACK_ABORT_EN
      nack_n     = nack;
`endif
      // Divider only runs during a transfer, so the first tick lands
      // exactly QDIV cycles after the accept edge.
      if (state == IDLE || tick) div_n = '0;
      else                       div_n = div + 1'b1;

      if (state == IDLE) begin
         if (go && !go_q) begin
            state_n    = START;
            shreg_n    = i2c_data;
            busy_n     = 1'b1;
            done_n     = 1'b0;
            ack_err_n  = 1'b0;
            quarter_n  = 2'd0;
            bit_idx_n  = 3'd0;
            byte_idx_n = 2'd0;
         end
      end else if (tick) begin
         quarter_n = quarter + 2'd1;
         case (state)
            START: begin
               case (quarter)
                  2'd0:    sda_oe_n = 1'b1;     // SDA falls with SCL high
                  2'd2:    scl_n    = 1'b0;
                  2'd3:    state_n  = BIT;
                  default: ;
               endcase
            end
            BIT: begin
               case (quarter)
                  2'd0:    sda_oe_n = ~shreg[23];
                  2'd1:    scl_n    = 1'b1;
                  2'd3: begin
                     scl_n     = 1'b0;
                     shreg_n   = {shreg[22:0], 1'b0};
                     bit_idx_n = bit_idx + 3'd1;   // wraps to 0 after bit 7
                     if (bit_idx == 3'd7) state_n = ACK;
                  end
                  default: ;
               endcase
            end
            ACK: begin
               case (quarter)
                  2'd0:    sda_oe_n = 1'b0;     // release for the slave
                  2'd1:    scl_n    = 1'b1;
                  2'd2: begin
                     ack_err_n = ack_err | i2c_sdat;
`ifdef I2C_NACK_ABORT_EN
                     nack_n    = i2c_sdat;
`endif
                  end
                  2'd3: begin
                     scl_n      = 1'b0;
                     byte_idx_n = byte_idx + 2'd1;
                     if (byte_idx == 2'd2) state_n = STOP;
                     else                  state_n = BIT;
`ifdef I2C_NACK_ABORT_EN
                     if (nack) state_n = STOP;
`endif
                  end
                  default: ;
               endcase
            end
            STOP: begin
               case (quarter)
                  2'd0:    sda_oe_n = 1'b1;     // SDA low while SCL low
                  2'd1:    scl_n    = 1'b1;
                  2'd2:    sda_oe_n = 1'b0;     // SDA rises with SCL high
                  2'd3: begin
                     busy_n  = 1'b0;
                     done_n  = 1'b1;
                     state_n = IDLE;
                  end
                  default: ;
               endcase
            end
            default: state_n = IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_i2c_write_master.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_i2c_write_master
// Purpose  : Self-checking bench for i2c_write_master with QDIV=4. A slave
//            model ACKs or NACKs a chosen byte; a bus monitor records the
//            bits seen on SCL rising edges and polices START/STOP placement.
//            Expected frames are queued when a request is issued and
//            compared when done rises.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_write_master;

   localparam int CLK_FREQ = 400;
   localparam int I2C_FREQ = 25;
   localparam int QDIV     = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        go = 1'b0;
   logic [23:0] i2c_data = 24'd0;
   logic        busy, done, ack_err, i2c_sclk;
   wire         sda;
   logic        slave_low = 1'b0;

   pullup (sda);
   assign sda = slave_low ? 1'b0 : 1'bz;

   i2c_write_master #(.CLK_FREQ(CLK_FREQ), .I2C_FREQ(I2C_FREQ)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .go       (go),
      .i2c_data (i2c_data),
      .busy     (busy),
      .done     (done),
      .ack_err  (ack_err),
      .i2c_sclk (i2c_sclk),
      .i2c_sdat (sda)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [26:0] bits;
      int          pulses;
      logic        aerr;
      int          lat;
      int          start;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got=%0h want=%0h (cycle %0d)", tag, got, want, cyc);
      end
   endtask

   // ---------------- bus monitor and slave model ----------------
   logic        prev_scl = 1'b1, prev_sda = 1'b1, prev_done = 1'b0;
   logic        in_xfer = 1'b0, rise_seen = 1'b0, rise_bit = 1'b0;
   logic [26:0] rx = 27'd0;
   int          bitcnt = 0;
   int          cur_nack = 0;
   int          done_cnt = 0;
   int          start_cnt = 0;

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            in_xfer   = 1'b0;
            rise_seen = 1'b0;
            slave_low = 1'b0;
            bitcnt    = 0;
         end else begin
            if (prev_scl && i2c_sclk && prev_sda && !sda) begin
               check_eq("start_idle", 32'(in_xfer), 32'd0);
               in_xfer   = 1'b1;
               rise_seen = 1'b0;
               bitcnt    = 0;
               rx        = 27'd0;
               start_cnt++;
            end else if (prev_scl && i2c_sclk && !prev_sda && sda) begin
               check_eq("stop_pos", 32'((bitcnt > 0) && (bitcnt % 9 == 0)), 32'd1);
               in_xfer = 1'b0;
            end
            if (!prev_scl && i2c_sclk) begin
               rise_bit  = sda;
               rise_seen = 1'b1;
            end
            // A bit counts as a full SCL pulse only once SCL falls again,
            // so the STOP-time SCL rise is never recorded.
            if (prev_scl && !i2c_sclk && in_xfer && rise_seen) begin
               rise_seen = 1'b0;
               rx        = {rx[25:0], rise_bit};
               bitcnt++;
               if (bitcnt % 9 == 8) slave_low = ((bitcnt / 9 + 1) != cur_nack);
               else                 slave_low = 1'b0;
            end
            if (done && !prev_done) begin
               done_cnt++;
               if (sb.size() == 0) begin
                  check_eq("spurious_done", 32'd1, 32'd0);
               end else begin
                  e = sb.pop_front();
                  check_eq("bits",    32'(rx),          32'(e.bits));
                  check_eq("pulses",  32'(bitcnt),      32'(e.pulses));
                  check_eq("ack_err", 32'(ack_err),     32'(e.aerr));
                  check_eq("latency", 32'(cyc - e.start), 32'(e.lat));
                  check_eq("busy_end", 32'(busy),       32'd0);
                  check_eq("scl_end", 32'(i2c_sclk),    32'd1);
                  check_eq("sda_end", 32'(sda),         32'd1);
               end
            end
         end
         prev_scl  = i2c_sclk;
         prev_sda  = sda;
         prev_done = done;
      end
   end

   // ---------------- stimulus ----------------
   task automatic send(input logic [23:0] d, input int nk);
      exp_t       e;
      logic [7:0] byte_v;
      e.bits   = 27'd0;
      e.pulses = 0;
      for (int b = 0; b < 3; b++) begin
         byte_v = d[23 - 8*b -: 8];
         for (int i = 7; i >= 0; i--) e.bits = {e.bits[25:0], byte_v[i]};
         e.bits   = {e.bits[25:0], (b + 1 == nk)};
         e.pulses += 9;
`ifdef I2C_NACK_ABORT_EN
         if (b + 1 == nk) break;
`endif
      end
      e.aerr = (nk != 0);
`ifdef I2C_NACK_ABORT_EN
      e.lat = (nk != 0) ? (8 + 36*nk) * QDIV : 116 * QDIV;
`else
      e.lat = 116 * QDIV;
`endif
      @(negedge clk);
      go = 1'b0;
      @(negedge clk);
      i2c_data = d;
      cur_nack = nk;
      e.start  = cyc + 1;
      sb.push_back(e);
      go = 1'b1;
   endtask

   task automatic wait_done(input int n0, input string tag);
      bool_loop: for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (done_cnt > n0) return;
      end
      check_eq(tag, 32'd0, 32'd1);
   endtask

   task automatic check_idle_outputs(input string tag);
      check_eq({tag, "_scl"},  32'(i2c_sclk), 32'd1);
      check_eq({tag, "_sda"},  32'(sda),      32'd1);
      check_eq({tag, "_busy"}, 32'(busy),     32'd0);
      check_eq({tag, "_done"}, 32'(done),     32'd0);
      check_eq({tag, "_aerr"}, 32'(ack_err),  32'd0);
   endtask

   initial begin
      int n0;
      int s0;
      logic [23:0] d;

      repeat (3) @(negedge clk);
      check_idle_outputs("rst");
      rst_n = 1'b1;

      // all bytes ACKed
      n0 = done_cnt;
      send(24'h340C00, 0);
      @(negedge clk);
      check_eq("busy_accept", 32'(busy), 32'd1);
      check_eq("done_clear",  32'(done), 32'd0);
      wait_done(n0, "timeout_ack");

      // slave NACKs the second byte
      n0 = done_cnt;
      send(24'h340C00, 2);
      wait_done(n0, "timeout_nack2");

      // re-triggering go while busy is ignored; holding go high after done
      // does not start another transfer
      n0 = done_cnt;
      send(24'h1A2B3C, 0);
      repeat (100) @(negedge clk);
      go = 1'b0;
      @(negedge clk);
      go = 1'b1;
      wait_done(n0, "timeout_retrig");
      s0 = start_cnt;
      repeat (200) @(negedge clk);
      check_eq("hold_busy",   32'(busy),      32'd0);
      check_eq("hold_done",   32'(done),      32'd1);
      check_eq("hold_starts", 32'(start_cnt), 32'(s0));
      go = 1'b0;

      // reset in the middle of a transfer
      send(24'hA5F00F, 0);
      repeat (150) @(negedge clk);
      #2;
      rst_n     = 1'b0;
      go        = 1'b0;
      slave_low = 1'b0;
      #1;
      check_idle_outputs("midrst");
      sb.delete();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // back-to-back frames with random data and NACK position
      for (int k = 0; k < 11; k++) begin
         d  = 24'($urandom);
         n0 = done_cnt;
         send(d, int'($urandom_range(0, 3)));
         wait_done(n0, "timeout_b2b");
      end
      go = 1'b0;
      repeat (4) @(negedge clk);
      check_eq("sb_empty", 32'(sb.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/i2c_write_master.md
Name: i2c_write_master

Overview:
- Bit-level I2C write engine that sits directly below the codec configuration sequencer. It consumes one 24-bit frame {slave_addr+W, reg_hi, reg_lo} per request and serialises it onto the two-wire bus as START, 3 bytes each followed by an ACK slot, then STOP.
- Runs on the system clock with an internal quarter-bit tick generator, so no divided clock is needed. It reports completion and an ACK-error flag back to the sequencer.

Parameters:
- CLK_FREQ, 200000000: system clock frequency in Hz.
- I2C_FREQ, 20000: SCL frequency in Hz.
- QDIV: derived localparam, CLK_FREQ/(4*I2C_FREQ), equal to clk cycles per quarter bit (2500 at defaults). Must be ≥2; elaboration error otherwise.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- go  in  1  transfer request; a transfer starts on the rising edge of go while idle
- i2c_data  in  24  frame to send, MSB first; [23:16] address byte, [15:8], [7:0]
- busy  out  1  high from accept until completion
- done  out  1  sticky completion flag
- ack_err  out  1  1 = at least one NACK seen in the last transfer; valid while done=1
- i2c_sclk  out  1  SCL, push-pull
- i2c_sdat  inout  1  SDA, open-drain: driven 0 or Z, never driven 1

Behaviour:
- Reset (async, immediate):
  - i2c_sclk=1, SDA=Z, busy=0, done=0, ack_err=0, state=IDLE, divider=0, go edge register=0.
  - Reset during a transfer abandons the bus mid-byte; there is no recovery sequence.
- Accept: in IDLE, go=1 with go_q=0 (go_q is go registered every clk).
  - Latch i2c_data into the shift register; busy←1, done←0, ack_err←0, phase counter←0.
  - Rising edges of go while not IDLE are ignored and lost.
  - go held high after completion does not restart a transfer.
- Tick generator:
  - Divider counts only while busy and is held at 0 in IDLE.
  - A tick fires when divider==QDIV-1, then the divider wraps to 0.
  - The first tick occurs QDIV cycles after the accept edge.
  - All SCL/SDA/state updates happen only on ticks.
- States and quarter actions (q0..q3, one per tick):
  - START: q0 SDA←0 (SCL=1); q1 hold; q2 SCL←0; q3 hold; then go to BIT, bit 23.
  - BIT: q0 SDA←current bit (0→drive 0, 1→Z); q1 SCL←1; q2 hold; q3 SCL←0. Shift left. After bits 23..16, 15..8 and 7..0 go to ACK.
  - ACK: q0 SDA←Z; q1 SCL←1; q2 sample SDA into nack (1 = NACK) and set ack_err←ack_err|nack; q3 SCL←0. Then go to BIT if bytes remain, otherwise STOP.
  - STOP: q0 SDA←0; q1 SCL←1; q2 SDA←Z; q3 hold. On the q3 tick: busy←0, done←1, state←IDLE.
- Timing and bus rules:
  - Total transfer = 4 + 27×4 + 4 = 116 ticks.
  - busy falls and done rises exactly 116×QDIV clk cycles after the accept edge.
  - SDA changes only while SCL=0, except the START and STOP edges.
- done semantics:
  - Stays 1 until the next accept, because the upstream sequencer samples it on a slow clock.
  - ack_err is held stable alongside done.
- Bit order is MSB first. The R/W bit is i2c_data[16] as supplied; the block never modifies it.

Optional Feature:
- Macro: I2C_NACK_ABORT_EN.
- Defined: a NACK sampled in any ACK slot sends the state to STOP after that slot's q3 and skips the remaining bytes; ack_err=1.
  - Completion after a NACK on byte n (n=1..3) = (4 + 36n + 4)×QDIV cycles.
- Undefined: all three bytes are always sent; ack_err is the OR of the three ACK samples.

Test Plan:
- Reset: hold rst_n=0 → i2c_sclk=1, SDA=Z, busy=0, done=0, ack_err=0; drop reset mid-transfer → same values in the same cycle.
- CLK_FREQ=400, I2C_FREQ=25 (QDIV=4), slave model ACKs all, go rising with data 24'h340C00:
  - Bits on SCL rise read 00110100,0,00001100,0,00000000,0.
  - done=1 and busy=0 at cycle 464; ack_err=0.
- Slave NACKs byte 2, macro undefined → 27 SCL pulses, done at 464, ack_err=1.
- Same stimulus, macro defined → STOP follows ACK slot 2; done at 80×4=320 cycles; ack_err=1; 18 SCL pulses.
- go toggles 1→0→1 at cycle 100 while busy → ignored; go held high after done → no new START; busy stays 0.
- Protocol monitor across 11 back-to-back frames: SDA never changes while SCL=1 except START/STOP; SDA is never driven to 1; each transfer ends with SCL=1, SDA=Z.
